// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - round-robin arbiter sharing one toggle-handshake SPI master
// One transfer in flight at a time; the ack toggle crosses in through a 2-flop synchronizer.
module spi_cmd_arbiter #(
  parameter int TRAN_WIDTH     = 24,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        c_clk_100m,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_Req,
  input  logic [N_REQ*TRAN_WIDTH-1:0] i_Req_Data,
  output logic [N_REQ-1:0]            o_Done,
  output logic [TRAN_WIDTH-1:0]       o_Rx_Data,
  output logic                        o_Busy,
  output logic                        o_Timeout_Err,
  output logic                        o_SPI_Send_Sync,
  output logic [TRAN_WIDTH-1:0]       o_SPI_Send_Data,
  input  logic                        i_SPI_Send_Over_ack,
  input  logic [TRAN_WIDTH-1:0]       i_SPI_Receive_Data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_ACK,
    DONE
  } state_t;

  state_t                 state;
  logic                   ack_meta;
  logic                   ack_s;
  logic                   ack_last;
  logic                   ack_event;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       cur_idx;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       scan_idx;
  logic                   grant_valid;
  logic [TRAN_WIDTH-1:0]  cur_word;
  logic [CNT_W-1:0]       wait_cnt;
  logic [TRAN_WIDTH-1:0]  req_words [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_words
    assign req_words[k] = i_Req_Data[k*TRAN_WIDTH +: TRAN_WIDTH];
  end

  always_ff @(posedge c_clk_100m) begin
    ack_meta <= i_SPI_Send_Over_ack;
    ack_s    <= ack_meta;
  end

  assign ack_event = (ack_s != ack_last);

  // Scan upward from the requester after the last one served; first hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = last_idx;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      if (!grant_valid && i_Req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge c_clk_100m) begin
    if (i_rst) begin
      state           <= IDLE;
      last_idx        <= IDX_LAST;
      cur_idx         <= '0;
      cur_word        <= '0;
      wait_cnt        <= '0;
      ack_last        <= ack_s;
      o_Done          <= '0;
      o_Rx_Data       <= '0;
      o_Busy          <= 1'b0;
      o_Timeout_Err   <= 1'b0;
      o_SPI_Send_Sync <= 1'b0;
      o_SPI_Send_Data <= '0;
    end else begin
      o_Done        <= '0;
      o_Timeout_Err <= 1'b0;
      case (state)
        IDLE: begin
          ack_last <= ack_s;
          if (|i_Req) begin
            state  <= ARB;
            o_Busy <= 1'b1;
          end
        end
        ARB: begin
          if (grant_valid) begin
            cur_idx  <= grant_idx;
            cur_word <= req_words[grant_idx];
            state    <= LAUNCH;
          end else begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end
        LAUNCH: begin
          o_SPI_Send_Data <= cur_word;
          o_SPI_Send_Sync <= ~o_SPI_Send_Sync;
          wait_cnt        <= '0;
          state           <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_event) begin
            o_Rx_Data <= i_SPI_Receive_Data;
            ack_last  <= ack_s;
            state     <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            o_Timeout_Err <= 1'b1;
            last_idx      <= cur_idx;
            state         <= IDLE;
            o_Busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          o_Done   <= N_REQ'(1) << cur_idx;
          last_idx <= cur_idx;
          state    <= IDLE;
          o_Busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb/tb_spi_cmd_arbiter.sv - directed bench for spi_cmd_arbiter with a toggle-ack SPI master model
module tb_spi_cmd_arbiter;

  localparam int TW = 24;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam logic [TW-1:0] MASK = 24'h999999;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*TW-1:0]  req_data;
  logic [NR-1:0]     done;
  logic [TW-1:0]     rx_data;
  logic              busy;
  logic              timeout_err;
  logic              send_sync;
  logic [TW-1:0]     send_data;
  logic              ack;
  logic [TW-1:0]     spi_rx;

  int n_pass = 0;
  int n_checks = 0;
  int starts = 0;
  int resp_delay = 3;
  bit ack_en = 1'b1;
  logic [TW-1:0] words [NR];

  always #5 clk = ~clk;

  spi_cmd_arbiter #(
    .TRAN_WIDTH(TW),
    .N_REQ(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .c_clk_100m(clk),
    .i_rst(rst),
    .i_Req(req),
    .i_Req_Data(req_data),
    .o_Done(done),
    .o_Rx_Data(rx_data),
    .o_Busy(busy),
    .o_Timeout_Err(timeout_err),
    .o_SPI_Send_Sync(send_sync),
    .o_SPI_Send_Data(send_data),
    .i_SPI_Send_Over_ack(ack),
    .i_SPI_Receive_Data(spi_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_done(input int budget, output logic [NR-1:0] d);
    int i;
    d = '0;
    i = 0;
    while (i < budget && d == '0) begin
      @(negedge clk);
      d = done;
      i++;
    end
  endtask

  task automatic wait_sync(input int budget, output int n);
    logic s0;
    s0 = send_sync;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (send_sync !== s0) break;
    end
  endtask

  task automatic watch_quiet(input int cycles, output logic any_done);
    any_done = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      any_done = any_done | (|done);
    end
  endtask

  // SPI master model: every start toggle is answered with an ack toggle and word ^ MASK.
  initial begin
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (send_sync !== seen) begin
        seen = send_sync;
        starts++;
        if (ack_en) begin
          repeat (resp_delay) @(negedge clk);
          spi_rx = send_data ^ MASK;
          ack = ~ack;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] d;
    logic [NR-1:0] exp_d;
    logic          quiet;
    int            n;

    words[0] = 24'hA5A5A5;
    words[1] = 24'h123456;
    words[2] = 24'h0F0F0F;
    words[3] = 24'hC0FFEE;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    ack = 1'b0;
    spi_rx = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    check("rst_sync", 32'(send_sync), 32'd0);
    check("rst_send", 32'(send_data), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) req_data[k*TW +: TW] = words[k];

    // single request: 3-edge launch latency, then completion
    req = 4'b0001;
    @(negedge clk);
    check("lat1_busy", 32'(busy), 32'd1);
    check("lat1_sync", 32'(send_sync), 32'd0);
    @(negedge clk);
    check("lat2_sync", 32'(send_sync), 32'd0);
    @(negedge clk);
    check("lat3_sync", 32'(send_sync), 32'd1);
    check("lat3_mosi", 32'(send_data), 32'hA5A5A5);
    req = '0;
    wait_done(100, d);
    check("single_done", 32'(d), 32'b0001);
    check("single_rx", 32'(rx_data), 32'h3C3C3C);
    @(negedge clk);
    check("single_pulse", 32'(done), 32'd0);
    check("single_hold", 32'(rx_data), 32'h3C3C3C);
    check("single_idle", 32'(busy), 32'd0);
    check("single_starts", 32'(starts), 32'd1);

    // all four requesting after reset: order 0,1,2,3,0
    ack_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(100, d);
      exp_d = 4'b0001 << (k % NR);
      check($sformatf("rr_done%0d", k), 32'(d), 32'(exp_d));
      check($sformatf("rr_rx%0d", k), 32'(rx_data), 32'(words[k % NR] ^ MASK));
      if (k == 4) req = '0;
      @(negedge clk);
      check($sformatf("rr_pulse%0d", k), 32'(done), 32'd0);
    end

    // requester 2 held: back-to-back with launch gap after each done
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_done(100, d);
      check($sformatf("b2b_done%0d", k), 32'(d), 32'b0100);
      if (k < 2) begin
        wait_sync(50, n);
        check($sformatf("b2b_gap%0d", k), 32'(n >= 2 && n < 50), 32'd1);
      end else begin
        req = '0;
      end
    end
    repeat (2) @(negedge clk);

    // request withdrawn before arbitration: no launch
    req = 4'b0001;
    @(negedge clk);
    check("wd_busy_arb", 32'(busy), 32'd1);
    req = '0;
    repeat (6) @(negedge clk);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_starts", 32'(starts), 32'd10);
    check("wd_sync", 32'(send_sync), 32'd0);

    // stuck ack: timeout 16 cycles after launch, no done, late ack absorbed
    ack_en = 1'b0;
    req = 4'b0010;
    wait_sync(20, n);
    check("tmo_launch_lat", 32'(n), 32'd3);
    req = '0;
    n = 0;
    quiet = 1'b0;
    while (n < 40 && timeout_err !== 1'b1) begin
      @(negedge clk);
      n++;
      quiet = quiet | (|done);
    end
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_no_done", 32'(quiet), 32'd0);
    @(negedge clk);
    check("tmo_pulse", 32'(timeout_err), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    ack = ~ack;
    watch_quiet(6, quiet);
    check("tmo_late_ack", 32'(quiet), 32'd0);
    check("tmo_late_busy", 32'(busy), 32'd0);
    ack_en = 1'b1;
    req = 4'b0010;
    wait_done(100, d);
    req = '0;
    check("tmo_next_done", 32'(d), 32'b0010);
    check("tmo_next_rx", 32'(rx_data), 32'(words[1] ^ MASK));
    repeat (2) @(negedge clk);

    // reset during WAIT_ACK: abort, then requester 0 wins first
    ack_en = 1'b0;
    req = 4'b1000;
    wait_sync(20, n);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rx", 32'(rx_data), 32'd0);
    check("abort_send", 32'(send_data), 32'd0);
    check("abort_sync", 32'(send_sync), 32'd0);
    check("abort_tmo", 32'(timeout_err), 32'd0);
    @(negedge clk);
    ack = ~ack;
    watch_quiet(6, quiet);
    check("abort_late_ack", 32'(quiet), 32'd0);
    ack_en = 1'b1;
    req = 4'b1001;
    wait_done(100, d);
    req = '0;
    check("abort_next_done", 32'(d), 32'b0001);
    check("abort_next_rx", 32'(rx_data), 32'h3C3C3C);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
